tc_pl_cap_gain_lmh_rx: RTL and testbench

Responder end of the cap-gain SPI register-write link. Consumes the byte stream from the SPI receive path, frames two-byte commands (byte0 = data, byte1 = {rw, addr[6:0]}) and writes a small gain register bank. It exposes the LMH gain field directly and reports malformed frames. It sits behind the SPI slave byte deserializer on the far side of the link driven by the cap-gain TX sequencer.

---
 rtl/tc_pl_cap_gain_pkg.sv | 20 ++
 rtl/tc_pl_cap_gain_regbank.sv | 36 +++
 rtl/tc_pl_cap_gain_lmh_rx.sv | 172 +++++++++++++++++
 tb/tb_tc_pl_cap_gain_lmh_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pl_cap_gain_pkg.sv
// rtl/tc_pl_cap_gain_pkg.sv - shared definitions for the cap-gain SPI register-write link
// Holds the responder FSM state encoding, the command byte field positions and
// the default LMH register index shared with the TX sequencer.
package tc_pl_cap_gain_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_COMMIT = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  // byte1 layout: {rw, addr[6:0]}
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 6;

  // Register index that carries the LMH gain field.
  localparam int LMH_ADDR_DEF = 2;

endpackage

// File: rtl/tc_pl_cap_gain_regbank.sv
// rtl/tc_pl_cap_gain_regbank.sv - NREG x W gain register bank with single write port
// Ports:
//   clk, rst   clock, asynchronous active-low reset (clears every register)
//   we         write enable for one cycle
//   waddr      7-bit register address; must be < NREG when we is high
//   wdata      value written to register waddr
//   bank       flat read bus, register i at [i*W +: W]
module tc_pl_cap_gain_regbank #(
  parameter int W    = 6,
  parameter int NREG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [6:0]          waddr,
  input  logic [W-1:0]        wdata,
  output logic [NREG*W-1:0]   bank
);

  logic [NREG*W-1:0] bank_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (waddr == 7'(i)) begin
          bank_q[i*W +: W] <= wdata;
        end
      end
    end
  end

  assign bank = bank_q;

endmodule

// File: rtl/tc_pl_cap_gain_lmh_rx.sv
// rtl/tc_pl_cap_gain_lmh_rx.sv - cap-gain SPI responder: frames 2-byte writes into the gain bank
// Optional readback is enabled by defining CAP_GAIN_RX_RDBK_EN.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   srx_frame              chip-select active
//   srx_valid, srx_data    received byte strobe and byte
//   reg_bank               flat register bank, reg i at [i*CAP0_13 +: CAP0_13]
//   gset_lmh               copy of register LMH_ADDR
//   wr_stb, wr_addr        write pulse and address of the last write (held)
//   err_addr               pulse: command addressed a register >= NREG
//   err_frame              pulse: short frame, timeout, or unsupported read
//   rdbk_valid, rdbk_data  readback pulse and zero-extended value (CAP_GAIN_RX_RDBK_EN only)
module tc_pl_cap_gain_lmh_rx
  import tc_pl_cap_gain_pkg::*;
#(
  parameter int CAP0_13  = 6,
  parameter int SPI0_0   = 8,
  parameter int NREG     = 4,
  parameter int LMH_ADDR = LMH_ADDR_DEF,
  parameter int TMO_CYC  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      srx_frame,
  input  logic                      srx_valid,
  input  logic [SPI0_0-1:0]         srx_data,
  output logic [NREG*CAP0_13-1:0]   reg_bank,
  output logic [CAP0_13-1:0]        gset_lmh,
  output logic                      wr_stb,
  output logic [6:0]                wr_addr,
  output logic                      err_addr,
  output logic                      err_frame
`ifdef CAP_GAIN_RX_RDBK_EN
  ,
  output logic                      rdbk_valid,
  output logic [SPI0_0-1:0]         rdbk_data
`endif
);

  localparam int              TW       = $clog2(TMO_CYC) + 1;
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [6:0]      NREG_A   = 7'(NREG);

  state_t              state, state_n;
  logic [CAP0_13-1:0]  dbuf;
  logic [6:0]          addr;
  logic                rw;
  logic [TW-1:0]       timer;

  logic ld_dbuf, ld_addr, wr_en, err_addr_n, err_frame_n, addr_ok;
`ifdef CAP_GAIN_RX_RDBK_EN
  logic                rd_en;
  logic [CAP0_13-1:0]  rd_val;
`endif

  assign addr_ok = (addr < NREG_A);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    ld_dbuf     = 1'b0;
    ld_addr     = 1'b0;
    wr_en       = 1'b0;
    err_addr_n  = 1'b0;
    err_frame_n = 1'b0;
`ifdef CAP_GAIN_RX_RDBK_EN
    rd_en       = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (srx_valid && srx_frame) begin
          ld_dbuf = 1'b1;
          state_n = S_ADDR;
        end
      end
      S_ADDR: begin
        // A byte arriving on the same cycle as CS falling or the timeout still completes the frame.
        if (srx_valid) begin
          ld_addr = 1'b1;
          state_n = S_COMMIT;
        end else if (!srx_frame || (timer == TMO_LAST)) begin
          err_frame_n = 1'b1;
          state_n     = S_IDLE;
        end
      end
      S_COMMIT: begin
        if (!rw) begin
          if (addr_ok) wr_en      = 1'b1;
          else         err_addr_n = 1'b1;
        end else begin
`ifdef CAP_GAIN_RX_RDBK_EN
          if (addr_ok) rd_en      = 1'b1;
          else         err_addr_n = 1'b1;
`else
          err_frame_n = 1'b1;
`endif
        end
        state_n = srx_frame ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!srx_frame) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbuf      <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      timer     <= '0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      err_addr  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (ld_dbuf) begin
        dbuf  <= srx_data[CAP0_13-1:0];
        timer <= '0;
      end else if (state == S_ADDR) begin
        timer <= timer + 1'b1;
      end
      if (ld_addr) begin
        addr <= srx_data[ADDR_MSB:0];
        rw   <= srx_data[RW_BIT];
      end
      wr_stb    <= wr_en;
      err_addr  <= err_addr_n;
      err_frame <= err_frame_n;
      if (wr_en) wr_addr <= addr;
    end
  end

  tc_pl_cap_gain_regbank #(
    .W    (CAP0_13),
    .NREG (NREG)
  ) u_regbank (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (addr),
    .wdata (dbuf),
    .bank  (reg_bank)
  );

  assign gset_lmh = reg_bank[LMH_ADDR*CAP0_13 +: CAP0_13];

`ifdef CAP_GAIN_RX_RDBK_EN
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == 7'(i)) rd_val = reg_bank[i*CAP0_13 +: CAP0_13];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdbk_valid <= 1'b0;
      rdbk_data  <= '0;
    end else begin
      rdbk_valid <= rd_en;
      if (rd_en) rdbk_data <= SPI0_0'(rd_val);
    end
  end
`endif

endmodule

// File: tb/tb_tc_pl_cap_gain_lmh_rx.sv
// tb/tb_tc_pl_cap_gain_lmh_rx.sv - self-checking bench for tc_pl_cap_gain_lmh_rx
module tb_tc_pl_cap_gain_lmh_rx;

  localparam int W    = 6;
  localparam int NREG = 4;
  localparam int TMO  = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         srx_frame, srx_valid;
  logic [7:0]   srx_data;
  logic [NREG*W-1:0] reg_bank;
  logic [W-1:0] gset_lmh;
  logic         wr_stb, err_addr, err_frame;
  logic [6:0]   wr_addr;
`ifdef CAP_GAIN_RX_RDBK_EN
  logic         rdbk_valid;
  logic [7:0]   rdbk_data;
`endif

  always #5 clk = ~clk;

  tc_pl_cap_gain_lmh_rx dut (
    .clk       (clk),
    .rst       (rst),
    .srx_frame (srx_frame),
    .srx_valid (srx_valid),
    .srx_data  (srx_data),
    .reg_bank  (reg_bank),
    .gset_lmh  (gset_lmh),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .err_addr  (err_addr),
    .err_frame (err_frame)
`ifdef CAP_GAIN_RX_RDBK_EN
    ,
    .rdbk_valid(rdbk_valid),
    .rdbk_data (rdbk_data)
`endif
  );

  int checks = 0;
  int errors = 0;

  // pulse counters, sampled 2 time units after each rising edge
  int n_wr = 0, n_ea = 0, n_ef = 0, n_rd = 0;
  logic [7:0] last_rd = '0;
  always @(posedge clk) begin
    #2;
    if (wr_stb)    n_wr++;
    if (err_addr)  n_ea++;
    if (err_frame) n_ef++;
`ifdef CAP_GAIN_RX_RDBK_EN
    if (rdbk_valid) begin
      n_rd++;
      last_rd = rdbk_data;
    end
`endif
  end

  // reference model: register contents, last write address, expected pulse counts
  logic [W-1:0] m_reg [NREG];
  logic [6:0]   m_waddr;
  int           e_wr = 0, e_ea = 0, e_ef = 0, e_rd = 0;
  logic [7:0]   e_rdval = '0;

  function automatic logic [NREG*W-1:0] m_flat();
    logic [NREG*W-1:0] f;
    for (int i = 0; i < NREG; i++) f[i*W +: W] = m_reg[i];
    return f;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_waddr = '0;
  endtask

  // one complete two-byte command
  task automatic m_cmd(input logic [7:0] b0, input logic [7:0] b1);
    int a;
    a = int'(b1[6:0]);
    if (b1[7]) begin
`ifdef CAP_GAIN_RX_RDBK_EN
      if (a < NREG) begin
        e_rd++;
        e_rdval = {2'b00, m_reg[a]};
      end else begin
        e_ea++;
      end
`else
      e_ef++;
`endif
    end else if (a < NREG) begin
      m_reg[a] = b0[W-1:0];
      m_waddr  = b1[6:0];
      e_wr++;
    end else begin
      e_ea++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".bank"},  32'(reg_bank), 32'(m_flat()));
    chk({tag, ".lmh"},   32'(gset_lmh), 32'(m_reg[2]));
    chk({tag, ".waddr"}, 32'(wr_addr),  32'(m_waddr));
    chk({tag, ".n_wr"},  n_wr, e_wr);
    chk({tag, ".n_ea"},  n_ea, e_ea);
    chk({tag, ".n_ef"},  n_ef, e_ef);
`ifdef CAP_GAIN_RX_RDBK_EN
    chk({tag, ".n_rd"},  n_rd, e_rd);
    if (e_rd > 0) chk({tag, ".rdval"}, 32'(last_rd), 32'(e_rdval));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    srx_valid = 1'b1;
    srx_data  = b;
    @(negedge clk);
    srx_valid = 1'b0;
    srx_data  = 8'h00;
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input int gap);
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(b0);
    idle(gap);
    send_byte(b1);
    idle(3);
    srx_frame = 1'b0;
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] b0, b1;
    rst = 1'b0; srx_frame = 1'b0; srx_valid = 1'b0; srx_data = '0;
    m_clear();
    idle(3);
    chk_all("reset");
    rst = 1'b1;
    idle(2);

    // 0x2A -> reg2 with cycle-exact latency from byte1
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(8'h2A);
    send_byte(8'h02);
    chk("lat.stb_early", 32'(wr_stb), 32'd0);
    @(negedge clk);
    chk("lat.stb", 32'(wr_stb), 32'd1);
    chk("lat.reg2", 32'(reg_bank[2*W +: W]), 32'h2A);
    @(negedge clk);
    chk("lat.stb_once", 32'(wr_stb), 32'd0);
    srx_frame = 1'b0;
    idle(3);
    m_cmd(8'h2A, 8'h02);
    chk_all("w2a");

    // data truncated to register width
    frame(8'hFF, 8'h00, 1);
    m_cmd(8'hFF, 8'h00);
    chk_all("wff");

    // out-of-range address
    frame(8'h11, 8'h05, 0);
    m_cmd(8'h11, 8'h05);
    chk_all("badaddr");

    // byte while CS low is ignored
    send_byte(8'h33);
    idle(3);
    chk_all("nocs");

    // short frame: CS drops after byte0
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(8'h15);
    idle(2);
    srx_frame = 1'b0;
    idle(3);
    e_ef++;
    chk_all("short");

    // timeout: err_frame on the TMO-th cycle after byte0
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(8'h15);
    k = 0;
    for (int i = 1; i <= 2*TMO; i++) begin
      @(negedge clk);
      if (err_frame) begin
        k = i;
        break;
      end
    end
    chk("tmo.cycle", k, TMO);
    srx_frame = 1'b0;
    idle(3);
    e_ef++;
    chk_all("tmo");

    // one command per CS: trailing bytes discarded
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(8'h07);
    send_byte(8'h01);
    send_byte(8'h09);
    idle(1);
    send_byte(8'h03);
    idle(2);
    srx_frame = 1'b0;
    idle(3);
    m_cmd(8'h07, 8'h01);
    chk_all("multi");

    // randomized commands
    for (int n = 0; n < 24; n++) begin
      b0 = 8'($urandom);
      b1 = {($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 7'($urandom_range(0, 5))};
      frame(b0, b1, $urandom_range(0, 3));
      m_cmd(b0, b1);
      chk_all("rand");
    end

    // reset mid-frame, then the still-active frame resumes from its next byte
    @(negedge clk);
    srx_frame = 1'b1;
    send_byte(8'h15);
    rst = 1'b0;
    #1;
    m_clear();
    chk("rst.bank",  32'(reg_bank),  32'd0);
    chk("rst.lmh",   32'(gset_lmh),  32'd0);
    chk("rst.waddr", 32'(wr_addr),   32'd0);
    chk("rst.pulse", 32'({wr_stb, err_addr, err_frame}), 32'd0);
    idle(3);
    rst = 1'b1;
    idle(1);
    send_byte(8'h0C);
    send_byte(8'h02);
    idle(3);
    srx_frame = 1'b0;
    idle(3);
    m_cmd(8'h0C, 8'h02);
    chk_all("post_rst");

    frame(8'h00, 8'h82, 1);
    m_cmd(8'h00, 8'h82);
    chk_all("rd82");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
